// File: rtl/isqrt_rr_scheduler_if.sv
// Requester, isqrt and status signals of the shared-isqrt scheduler.
// The slave side is the scheduler; the master side is the requesters plus the isqrt.
interface isqrt_rr_scheduler_if #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned XW       = 32,
  parameter int unsigned YW       = 16,
  parameter int unsigned SQRT_LAT = 16
);
  localparam int unsigned CW = $clog2(SQRT_LAT + 2);

  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ*XW-1:0] req_x;
  logic [N_REQ-1:0]    req_rdy;
  logic                sq_x_vld;
  logic [XW-1:0]       sq_x;
  logic                sq_y_vld;
  logic [YW-1:0]       sq_y;
  logic [N_REQ-1:0]    rsp_vld;
  logic [YW-1:0]       rsp_y;
  logic [CW-1:0]       inflight;
  logic                tag_err;

  modport master (
    output req_vld, req_x, sq_y_vld, sq_y,
    input  req_rdy, sq_x_vld, sq_x, rsp_vld, rsp_y, inflight, tag_err
  );

  modport slave (
    input  req_vld, req_x, sq_y_vld, sq_y,
    output req_rdy, sq_x_vld, sq_x, rsp_vld, rsp_y, inflight, tag_err
  );
endinterface

// File: rtl/isqrt_rr_scheduler.sv
// Round-robin sharing of one pipelined isqrt among N_REQ requesters; a tag
// pipeline matched to the isqrt latency routes each result back to its issuer.
module isqrt_rr_scheduler #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned XW       = 32,
  parameter int unsigned YW       = 16,
  parameter int unsigned SQRT_LAT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  isqrt_rr_scheduler_if.slave  bus
);
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW  = $clog2(SQRT_LAT + 2);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic [N_REQ-1:0] grant;

  logic [SQRT_LAT-1:0] tag_vld;
  logic [IDW-1:0]      tag_id [SQRT_LAT];
  logic                tag_out_vld;
  logic [IDW-1:0]      tag_out_id;

  logic [N_REQ-1:0] rsp_vld_q;
  logic [YW-1:0]    rsp_y_q;
  logic [CW-1:0]    inflight_q;
  logic             tag_err_q;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base,
                                              input int unsigned step);
    int unsigned s;
    s = 32'(base) + step;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  // Arbiter: first valid requester after the pointer, wrapping; nothing in reset
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!grant_any && bus.req_vld[wrap_inc(ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_inc(ptr, k);
      end
    end
    if (rst) begin
      grant_any = 1'b0;
      grant_idx = '0;
    end
  end

  assign grant        = grant_any ? onehot(grant_idx) : '0;
  assign bus.req_rdy  = grant;
  assign bus.sq_x_vld = grant_any;
  assign bus.sq_x     = grant_any ? bus.req_x[grant_idx*XW +: XW] : '0;

  // Tag valid bits: the only reset part of the tag pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= grant_any;
      for (int unsigned i = 1; i < SQRT_LAT; i++) tag_vld[i] <= tag_vld[i-1];
    end
  end

  // Tag ids move only alongside a valid tag
  always_ff @(posedge clk) begin
    if (grant_any) tag_id[0] <= grant_idx;
    for (int unsigned i = 1; i < SQRT_LAT; i++) begin
      if (tag_vld[i-1]) tag_id[i] <= tag_id[i-1];
    end
  end

  assign tag_out_vld = tag_vld[SQRT_LAT-1];
  assign tag_out_id  = tag_id[SQRT_LAT-1];

  // Pointer, return stage, in-flight count and sticky tag error
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= IDW'(N_REQ - 1);
      rsp_vld_q  <= '0;
      rsp_y_q    <= '0;
      inflight_q <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      if (grant_any) ptr <= grant_idx;

      rsp_vld_q <= '0;
      if (tag_out_vld && bus.sq_y_vld) begin
        rsp_vld_q <= onehot(tag_out_id);
        rsp_y_q   <= bus.sq_y;
      end

      if (tag_out_vld != bus.sq_y_vld) tag_err_q <= 1'b1;

      case ({grant_any, tag_out_vld})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign bus.rsp_vld  = rsp_vld_q;
  assign bus.rsp_y    = rsp_y_q;
  assign bus.inflight = inflight_q;
  assign bus.tag_err  = tag_err_q;

endmodule

// File: tb/tb_isqrt_rr_scheduler.sv
// Bench for isqrt_rr_scheduler: stands in for the isqrt, checks every cycle
// against a queue-based model, plus directed literal expectations.
module tb_isqrt_rr_scheduler;
  localparam int unsigned N_REQ    = 3;
  localparam int unsigned XW       = 32;
  localparam int unsigned YW       = 16;
  localparam int unsigned SQRT_LAT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_y = 1'b0;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  isqrt_rr_scheduler_if #(.N_REQ(N_REQ), .XW(XW), .YW(YW), .SQRT_LAT(SQRT_LAT)) bus();

  isqrt_rr_scheduler #(.N_REQ(N_REQ), .XW(XW), .YW(YW), .SQRT_LAT(SQRT_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int unsigned isqrt_ref(input longint unsigned x);
    longint unsigned r, t;
    r = 0;
    for (int b = YW - 1; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return int'(r);
  endfunction

  // Stand-in isqrt: fixed latency, flushed by the shared reset
  logic [SQRT_LAT-1:0] iq_vld;
  logic [YW-1:0]       iq_y [SQRT_LAT];
  always @(posedge clk) begin
    if (rst) iq_vld <= '0;
    else     iq_vld <= {iq_vld[SQRT_LAT-2:0], bus.sq_x_vld};
    iq_y[0] <= YW'(isqrt_ref(longint'(bus.sq_x)));
    for (int i = 1; i < SQRT_LAT; i++) iq_y[i] <= iq_y[i-1];
  end
  assign bus.sq_y_vld = iq_vld[SQRT_LAT-1] | force_y;
  assign bus.sq_y     = iq_y[SQRT_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: round-robin pick, queue of outstanding issues due SQRT_LAT later
  typedef struct {
    int unsigned     due;
    int unsigned     id;
    longint unsigned x;
  } pend_t;
  pend_t            q[$];
  int unsigned      m_ptr = 0;
  int unsigned      m_inflight = 0;
  bit               m_err = 1'b0;
  bit [N_REQ-1:0]   m_rsp_vld = '0;
  bit [YW-1:0]      m_rsp_y = '0;
  bit               m_on = 1'b0;

  always @(negedge clk) begin
    bit [N_REQ-1:0]  eg;
    bit              any;
    bit              ret;
    int unsigned     gi;
    int unsigned     j;
    longint unsigned ex;
    pend_t           p;
    eg = '0; any = 1'b0; gi = 0; ex = 0;
    if (!rst && m_on) begin
      for (int k = 1; k <= N_REQ; k++) begin
        j = (m_ptr + k) % N_REQ;
        if (!any && bus.req_vld[j]) begin
          any = 1'b1;
          gi  = j;
        end
      end
    end
    if (any) begin
      eg = N_REQ'(1) << gi;
      ex = longint'(bus.req_x[gi*XW +: XW]);
    end
    if (m_on) begin
      chk("req_rdy",  bus.req_rdy,  eg);
      chk("sq_x_vld", bus.sq_x_vld, any);
      chk("sq_x",     bus.sq_x,     ex);
      chk("rsp_vld",  bus.rsp_vld,  m_rsp_vld);
      chk("rsp_y",    bus.rsp_y,    m_rsp_y);
      chk("inflight", bus.inflight, m_inflight);
      chk("tag_err",  bus.tag_err,  m_err);
    end
    if (rst) begin
      q.delete();
      m_ptr = N_REQ - 1; m_inflight = 0; m_err = 1'b0;
      m_rsp_vld = '0; m_rsp_y = '0; m_on = 1'b1;
    end else if (m_on) begin
      ret = (q.size() > 0) && (q[0].due == cyc);
      m_rsp_vld = '0;
      if (ret != bus.sq_y_vld) m_err = 1'b1;
      if (ret && bus.sq_y_vld) begin
        m_rsp_vld = N_REQ'(1) << q[0].id;
        m_rsp_y   = YW'(isqrt_ref(q[0].x));
      end
      if (ret) begin
        void'(q.pop_front());
        m_inflight--;
      end
      if (any) begin
        p.due = cyc + SQRT_LAT; p.id = gi; p.x = ex;
        q.push_back(p);
        m_inflight++;
        m_ptr = gi;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.req_vld = '1;
    repeat (n) begin
      @(negedge clk);
      chk("rdy_in_rst", bus.req_rdy, 0);
      tick();
    end
    rst = 1'b0;
    bus.req_vld = '0;
  endtask

  task automatic set_x(input int i, input logic [XW-1:0] v);
    bus.req_x[i*XW +: XW] = v;
  endtask

  // Called at a negedge; returns at the negedge of the first response cycle
  task automatic wait_rsp(input string name, output int unsigned at, output bit ok);
    ok = 1'b0; at = 0;
    for (int k = 0; k < 64; k++) begin
      if (bus.rsp_vld != '0) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no rsp_vld within 64 cycles (cycle %0d)", name, cyc);
    end
  endtask

  initial begin
    int unsigned c0, at, cnt;
    bit ok, g;
    int unsigned y2[3];
    int unsigned y4[16];
    y2 = '{3, 5, 10};
    y4 = '{0, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3};
    bus.req_vld = '0;
    bus.req_x   = '0;
    #1;

    // 1: single request, exact latency
    do_reset(3);
    @(negedge clk);
    chk("rst_rsp_vld",  bus.rsp_vld, 0);
    chk("rst_rsp_y",    bus.rsp_y, 0);
    chk("rst_inflight", bus.inflight, 0);
    chk("rst_tag_err",  bus.tag_err, 0);
    tick();
    set_x(0, 16); bus.req_vld = 3'b001;
    @(negedge clk);
    chk("t1_grant", bus.req_rdy, 3'b001);
    chk("t1_sq_x", bus.sq_x, 16);
    c0 = cyc;
    tick();
    bus.req_vld = '0;
    @(negedge clk);
    chk("t1_inflight1", bus.inflight, 1);
    wait_rsp("t1_rsp", at, ok);
    if (ok) begin
      chk("t1_latency", at - c0, SQRT_LAT + 1);
      chk("t1_rsp_vld", bus.rsp_vld, 3'b001);
      chk("t1_rsp_y", bus.rsp_y, 4);
      chk("t1_inflight0", bus.inflight, 0);
    end
    tick();

    // 2: all three hold valid, rotating grants and in-order results
    do_reset(2);
    set_x(0, 9); set_x(1, 25); set_x(2, 100);
    bus.req_vld = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) c0 = cyc;
      chk("t2_grant", bus.req_rdy, 3'b001 << (i % 3));
      tick();
    end
    bus.req_vld = '0;
    @(negedge clk);
    wait_rsp("t2_rsp", at, ok);
    if (ok) begin
      chk("t2_latency", at - c0, SQRT_LAT + 1);
      for (int i = 0; i < 6; i++) begin
        chk("t2_rsp_vld", bus.rsp_vld, 3'b001 << (i % 3));
        chk("t2_rsp_y", bus.rsp_y, y2[i % 3]);
        @(negedge clk);
      end
    end
    tick();

    // 3: two requesters alternate, then req0 joins
    do_reset(2);
    set_x(0, 81); set_x(1, 49); set_x(2, 144);
    bus.req_vld = 3'b110;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_alt", bus.req_rdy, (i % 2 == 0) ? 3'b010 : 3'b100);
      tick();
    end
    bus.req_vld = 3'b111;
    g = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.req_rdy[0]) begin
        g = 1'b1;
        break;
      end
      tick();
    end
    chk("t3_req0_within3", g, 1);
    tick();
    bus.req_vld = '0;
    repeat (SQRT_LAT + 6) tick();

    // 4: 16 back-to-back issues fill the pipe
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      set_x(0, XW'(i)); bus.req_vld = 3'b001;
      tick();
    end
    bus.req_vld = '0;
    @(negedge clk);
    chk("t4_inflight_max", bus.inflight, SQRT_LAT);
    wait_rsp("t4_rsp", at, ok);
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        chk("t4_rsp_vld", bus.rsp_vld, 3'b001);
        chk("t4_rsp_y", bus.rsp_y, y4[i]);
        @(negedge clk);
      end
    end
    chk("t4_tag_err", bus.tag_err, 0);
    tick();

    // 5: reset while three results are in flight
    do_reset(2);
    set_x(0, 36); bus.req_vld = 3'b001;
    repeat (3) tick();
    bus.req_vld = '0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    repeat (SQRT_LAT + 5) begin
      @(negedge clk);
      if (bus.rsp_vld != '0) cnt++;
      tick();
    end
    chk("t5_no_rsp", cnt, 0);
    @(negedge clk);
    chk("t5_inflight", bus.inflight, 0);
    chk("t5_tag_err", bus.tag_err, 0);
    tick();
    bus.req_vld = 3'b111;
    @(negedge clk);
    chk("t5_first_grant", bus.req_rdy, 3'b001);
    tick();
    bus.req_vld = '0;
    repeat (SQRT_LAT + 4) tick();

    // 6: spurious y_vld with an empty tag pipe
    do_reset(2);
    force_y = 1'b1;
    tick();
    force_y = 1'b0;
    @(negedge clk);
    chk("t6_tag_err_set", bus.tag_err, 1);
    chk("t6_no_rsp", bus.rsp_vld, 0);
    tick();
    repeat (10) tick();
    @(negedge clk);
    chk("t6_tag_err_sticky", bus.tag_err, 1);
    tick();
    do_reset(1);
    @(negedge clk);
    chk("t6_tag_err_clr", bus.tag_err, 0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
